// File: rtl/gpio_mux_pkg.sv
// Shared definitions for the Wishbone GPIO pin router: register offsets,
// select width, commit FSM states and the select-code validity helper.
package gpio_mux_pkg;

  localparam int SEL_W = 8;

  localparam logic [7:0] OFF_CTRL   = 8'h80;
  localparam logic [7:0] OFF_ERR    = 8'h84;
  localparam logic [7:0] OFF_ACTIVE = 8'h88;

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    APPLY
  } state_e;

  // A select code routes a team only when it names one of teams 1..num_teams.
  function automatic logic sel_valid(input logic [SEL_W-1:0] code, input int num_teams);
    return (code != '0) && (int'(code) <= num_teams);
  endfunction

endpackage

// File: rtl/gpio_mux_ctrl_wb_pin.sv
// One pad's router: picks the selected team's out/oeb, or parks the pad
// hi-Z (out = 0) when the select is off/invalid or the guard mask is set.
module gpio_pin_mux
  import gpio_mux_pkg::*;
#(
  parameter int NUM_TEAMS = 12
) (
  input  logic [SEL_W-1:0]     sel,
  input  logic                 guard,
  input  logic [NUM_TEAMS-1:0] team_out,
  input  logic [NUM_TEAMS-1:0] team_oeb,
  output logic                 pad_out,
  output logic                 pad_oeb
);

  // Route the selected team to the pad; off/guarded pads float.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    pad_out = 1'b0;
    pad_oeb = 1'b1;
    if (!guard && sel_valid(sel, NUM_TEAMS)) begin
      for (int k = 1; k <= NUM_TEAMS; k++) begin
        if (sel == SEL_W'(k)) begin
          pad_out = team_out[k-1];
          pad_oeb = team_oeb[k-1];
        end
      end
    end
  end

endmodule

// File: rtl/gpio_mux_ctrl_wb.sv
// Wishbone GPIO pin router. Software stages per-pin selects in a shadow
// bank and commits them; changed pins float for a guard window before the
// new mapping becomes active, so a pad never hands over between drivers
// within one cycle.
module gpio_mux_ctrl_wb
  import gpio_mux_pkg::*;
#(
  parameter int          NUM_TEAMS    = 12,
  parameter int          NUM_PINS     = 38,
  parameter int          GUARD_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          wbs_stb_i,
  input  logic                          wbs_cyc_i,
  input  logic                          wbs_we_i,
  input  logic [3:0]                    wbs_sel_i,
  input  logic [31:0]                   wbs_adr_i,
  input  logic [31:0]                   wbs_dat_i,
  output logic                          wbs_ack_o,
  output logic [31:0]                   wbs_dat_o,
  input  logic [NUM_TEAMS*NUM_PINS-1:0] designs_gpio_out,
  input  logic [NUM_TEAMS*NUM_PINS-1:0] designs_gpio_oeb,
  output logic [NUM_PINS-1:0]           gpio_out,
  output logic [NUM_PINS-1:0]           gpio_oeb,
  output logic                          busy_o
);

  localparam int CNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  logic [SEL_W-1:0] shadow  [NUM_PINS];
  logic [SEL_W-1:0] pending [NUM_PINS];
  logic [SEL_W-1:0] active  [NUM_PINS];
  logic [1:0]       err_q;      // bit0 BAD_SEL, bit1 COMMIT_DROP
  logic [6:0]       act_idx;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic        hit, req, wr, sel_wr, busy;
  logic        commit_req, commit_go, commit_drop, bad_sel_wr;
  logic [7:0]  off;
  logic [4:0]  word;
  logic [1:0]  err_clr;
  logic [31:0] rdata;
  logic [NUM_PINS-1:0] guard_mask;

  assign hit         = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req         = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
  assign wr          = req & wbs_we_i;
  assign off         = wbs_adr_i[7:0];
  assign word        = off[6:2];
  assign sel_wr      = wr & ~off[7];
  assign busy        = (state_q != IDLE);
  assign busy_o      = busy;
  assign commit_req  = wr && (off == OFF_CTRL) && wbs_sel_i[0] && wbs_dat_i[0];
  assign commit_go   = commit_req & ~busy;
  assign commit_drop = commit_req & busy;
  assign err_clr     = (wr && (off == OFF_ERR) && wbs_sel_i[0]) ? wbs_dat_i[1:0] : 2'b00;

  // Flag any enabled byte write to an existing pin that names no team.
  always_comb begin
    bad_sel_wr = 1'b0;
    for (int p = 0; p < NUM_PINS; p++) begin
      if (sel_wr && (word == 5'(p / 4)) && wbs_sel_i[p % 4] &&
          (wbs_dat_i[8*(p%4) +: 8] != '0) &&
          !sel_valid(wbs_dat_i[8*(p%4) +: 8], NUM_TEAMS))
        bad_sel_wr = 1'b1;
    end
  end

  // Read mux for the whole 256-byte window; holes and missing pins read 0.
  always_comb begin
    rdata = '0;
    if (!off[7]) begin
      for (int p = 0; p < NUM_PINS; p++) begin
        if (word == 5'(p / 4)) rdata[8*(p%4) +: 8] = shadow[p];
      end
    end else begin
      case (off)
        OFF_CTRL: rdata = {30'b0, busy, 1'b0};
        OFF_ERR:  rdata = {30'b0, err_q};
        OFF_ACTIVE: begin
          for (int p = 0; p < NUM_PINS; p++) begin
            if (act_idx == 7'(p)) rdata = {24'b0, active[p]};
          end
        end
        default: rdata = '0;
      endcase
    end
  end

  // Single-cycle ack; read data is presented only alongside ack.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= req ? rdata : '0;
    end
  end

  // Software-visible registers: shadow selects, sticky errors, ACTIVE index.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      // NOTE: these select banks are small flop arrays, not RAM, so they are reset like any other state.
      for (int p = 0; p < NUM_PINS; p++) shadow[p] <= '0;
      err_q   <= '0;
      act_idx <= '0;
    end else begin
      for (int p = 0; p < NUM_PINS; p++) begin
        if (sel_wr && (word == 5'(p / 4)) && wbs_sel_i[p % 4])
          shadow[p] <= wbs_dat_i[8*(p%4) +: 8];
      end
      err_q <= (err_q | {commit_drop, bad_sel_wr}) & ~err_clr;
      if (wr && (off == OFF_ACTIVE) && wbs_sel_i[0]) act_idx <= wbs_dat_i[6:0];
    end
  end

  // Commit sequencing: IDLE -> GUARD (GUARD_CYCLES cycles) -> APPLY -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit_go) state_d = (GUARD_CYCLES == 0) ? APPLY : GUARD;
      GUARD:   if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, guard counter and the pending/active select banks.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int p = 0; p < NUM_PINS; p++) begin
        pending[p] <= '0;
        active[p]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == GUARD) ? cnt_q + 1'b1 : '0;
      if (commit_go) begin
        for (int p = 0; p < NUM_PINS; p++) pending[p] <= shadow[p];
      end
      if (state_q == APPLY) begin
        for (int p = 0; p < NUM_PINS; p++) active[p] <= pending[p];
      end
    end
  end

  // Changed pins stay parked through APPLY too, so the old driver never
  // reappears for a cycle before the new one takes over.
  for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
    logic [NUM_TEAMS-1:0] team_out, team_oeb;

    for (genvar k = 0; k < NUM_TEAMS; k++) begin : g_team
      assign team_out[k] = designs_gpio_out[k*NUM_PINS + p];
      assign team_oeb[k] = designs_gpio_oeb[k*NUM_PINS + p];
    end

    assign guard_mask[p] = busy & (pending[p] != active[p]);

    gpio_pin_mux #(.NUM_TEAMS(NUM_TEAMS)) u_pin_mux (
      .sel      (active[p]),
      .guard    (guard_mask[p]),
      .team_out (team_out),
      .team_oeb (team_oeb),
      .pad_out  (gpio_out[p]),
      .pad_oeb  (gpio_oeb[p])
    );
  end

endmodule

// File: tb/tb_gpio_mux_ctrl_wb.sv
// Directed bench for gpio_mux_ctrl_wb: register access, commit timing,
// guard masking, error flags, busy-time behaviour and mid-commit reset.
module tb_gpio_mux_ctrl_wb;

  localparam int          NT   = 12;
  localparam int          NP   = 38;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic                 wb_clk_i = 1'b0;
  logic                 wb_rst_i = 1'b1;
  logic                 wbs_stb_i = 1'b0;
  logic                 wbs_cyc_i = 1'b0;
  logic                 wbs_we_i = 1'b0;
  logic [3:0]           wbs_sel_i = 4'h0;
  logic [31:0]          wbs_adr_i = '0;
  logic [31:0]          wbs_dat_i = '0;
  logic                 wbs_ack_o;
  logic [31:0]          wbs_dat_o;
  logic [NT*NP-1:0]     designs_gpio_out;
  logic [NT*NP-1:0]     designs_gpio_oeb;
  logic [NP-1:0]        gpio_out;
  logic [NP-1:0]        gpio_oeb;
  logic                 busy_o;

  int            checks = 0;
  int            errors = 0;
  int            act_m [NP];
  logic [NP-1:0] mask_m;
  logic [31:0]   rd;
  logic          seen;
  logic [NP-1:0] eo, eb;

  gpio_mux_ctrl_wb #(
    .NUM_TEAMS    (NT),
    .NUM_PINS     (NP),
    .GUARD_CYCLES (4),
    .BASE_ADDR    (BASE)
  ) dut (
    .wb_clk_i         (wb_clk_i),
    .wb_rst_i         (wb_rst_i),
    .wbs_stb_i        (wbs_stb_i),
    .wbs_cyc_i        (wbs_cyc_i),
    .wbs_we_i         (wbs_we_i),
    .wbs_sel_i        (wbs_sel_i),
    .wbs_adr_i        (wbs_adr_i),
    .wbs_dat_i        (wbs_dat_i),
    .wbs_ack_o        (wbs_ack_o),
    .wbs_dat_o        (wbs_dat_o),
    .designs_gpio_out (designs_gpio_out),
    .designs_gpio_oeb (designs_gpio_oeb),
    .gpio_out         (gpio_out),
    .gpio_oeb         (gpio_oeb),
    .busy_o           (busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected pad vector from the bench's own active-select and mask model.
  function automatic logic [NP-1:0] exp_vec(input logic want_oeb);
    logic [NP-1:0] v;
    for (int p = 0; p < NP; p++) begin
      int k = act_m[p];
      if (mask_m[p] || k < 1 || k > NT) v[p] = want_oeb;
      else v[p] = want_oeb ? designs_gpio_oeb[(k-1)*NP + p] : designs_gpio_out[(k-1)*NP + p];
    end
    return v;
  endfunction

  task automatic pads_chk(input string tag, input logic busy_exp);
    check({tag, "_out"},  gpio_out, exp_vec(1'b0));
    check({tag, "_oeb"},  gpio_oeb, exp_vec(1'b1));
    check({tag, "_busy"}, busy_o,   busy_exp);
  endtask

  // One Wishbone transfer: request driven at a negedge, ack awaited with a bound.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [3:0] sel, output logic [31:0] rdat);
    int   n;
    logic got;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = wdat;
    wbs_sel_i = sel;
    n = 0;
    do begin
      @(negedge wb_clk_i);
      n++;
    end while (!wbs_ack_o && n < 8);
    got  = wbs_ack_o;
    rdat = wbs_dat_o;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    check("wb_ack", got, 1'b1);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    wb_xfer(1'b1, BASE + {24'b0, off}, d, s, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    wb_xfer(1'b0, BASE + {24'b0, off}, 32'h0, 4'hF, rd);
    check(tag, rd, exp);
  endtask

  initial begin
    for (int k = 0; k < NT; k++) begin
      for (int p = 0; p < NP; p++) begin
        designs_gpio_out[k*NP + p] = ((((k+1)*7 + p*13) & 4) != 0);
        designs_gpio_oeb[k*NP + p] = (((k+1+p) % 3) == 0);
      end
    end
    for (int p = 0; p < NP; p++) act_m[p] = 0;
    mask_m = '0;

    // Reset state
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    pads_chk("reset", 1'b0);
    check("reset_ack", wbs_ack_o, 1'b0);
    check("reset_dat", wbs_dat_o, 32'h0);
    rd_chk("rst_sel0", 8'h00, 32'h0);
    rd_chk("rst_sel9", 8'h24, 32'h0);
    rd_chk("rst_ctrl", 8'h80, 32'h0);
    rd_chk("rst_err",  8'h84, 32'h0);
    wr(8'h88, 32'h0, 4'hF);
    rd_chk("rst_active", 8'h88, 32'h0);

    // In-window hole: acked, reads 0. Out-of-window: never acked.
    wr(8'h8C, 32'hFFFF_FFFF, 4'hF);
    rd_chk("hole_rd", 8'h8C, 32'h0);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_adr_i = BASE + 32'h100;
    seen = 1'b0;
    repeat (4) begin
      @(negedge wb_clk_i);
      seen = seen | wbs_ack_o;
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    check("oow_noack", seen, 1'b0);

    // First commit: pin0 -> team2, pin1 -> team3, visible at T+6
    wr(8'h00, 32'h0000_0302, 4'hF);
    rd_chk("sel0_wr", 8'h00, 32'h0000_0302);
    wr(8'h80, 32'h1, 4'hF);
    for (int k = 1; k <= 5; k++) begin
      pads_chk($sformatf("c1_t%0d", k), 1'b1);
      @(negedge wb_clk_i);
    end
    act_m[0] = 2;
    act_m[1] = 3;
    pads_chk("c1_t6", 1'b0);

    // Pads follow design inputs combinationally
    designs_gpio_out = ~designs_gpio_out;
    #1;
    pads_chk("comb_in", 1'b0);

    // Remap pin0 to team5; pin1 keeps team3 throughout
    wr(8'h00, 32'h0000_0305, 4'hF);
    wr(8'h80, 32'h1, 4'hF);
    mask_m[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      pads_chk($sformatf("c2_t%0d", k), 1'b1);
      @(negedge wb_clk_i);
    end
    eo = exp_vec(1'b0);
    eb = exp_vec(1'b1);
    check("c2_t5_pin1_out", gpio_out[1], eo[1]);
    check("c2_t5_pin1_oeb", gpio_oeb[1], eb[1]);
    check("c2_t5_busy", busy_o, 1'b1);
    @(negedge wb_clk_i);
    mask_m[0] = 1'b0;
    act_m[0]  = 5;
    pads_chk("c2_t6", 1'b0);
    wr(8'h88, 32'd0, 4'hF);
    rd_chk("active0", 8'h88, 32'd5);
    wr(8'h88, 32'd1, 4'hF);
    rd_chk("active1", 8'h88, 32'd3);
    wr(8'h88, 32'd40, 4'hF);
    rd_chk("active40", 8'h88, 32'd0);

    // Invalid select code: BAD_SEL, pin stays off after commit
    wr(8'h08, 32'h0000_00FF, 4'hF);
    rd_chk("err_badsel", 8'h84, 32'h1);
    rd_chk("sel2_rd", 8'h08, 32'h0000_00FF);
    wr(8'h80, 32'h1, 4'hF);
    repeat (5) @(negedge wb_clk_i);
    act_m[8] = 255;
    pads_chk("c3_t6", 1'b0);
    wr(8'h84, 32'h1, 4'hF);
    rd_chk("err_clr", 8'h84, 32'h0);

    // Bytes for pins beyond NUM_PINS read 0 and raise no error
    wr(8'h24, 32'hFFFF_0707, 4'hF);
    rd_chk("sel9_trunc", 8'h24, 32'h0000_0707);
    rd_chk("sel9_noerr", 8'h84, 32'h0);

    // COMMIT and SEL write while the commit is in flight
    wr(8'h80, 32'h1, 4'hF);           // T
    wr(8'h80, 32'h1, 4'hF);           // sampled at T+2: dropped
    wr(8'h00, 32'h0000_0309, 4'hF);   // sampled at T+4: shadow only
    mask_m[36] = 1'b1;
    mask_m[37] = 1'b1;
    pads_chk("c4_t5", 1'b1);
    @(negedge wb_clk_i);
    mask_m[36] = 1'b0;
    mask_m[37] = 1'b0;
    act_m[36]  = 7;
    act_m[37]  = 7;
    pads_chk("c4_t6", 1'b0);
    rd_chk("err_drop", 8'h84, 32'h2);
    rd_chk("sel0_busywr", 8'h00, 32'h0000_0309);
    wr(8'h88, 32'd0, 4'hF);
    rd_chk("active0_old", 8'h88, 32'd5);
    wr(8'h88, 32'd36, 4'hF);
    rd_chk("active36", 8'h88, 32'd7);
    wr(8'h84, 32'h3, 4'hF);
    rd_chk("err_clr2", 8'h84, 32'h0);

    // Reset in the middle of GUARD
    wr(8'h80, 32'h1, 4'hF);
    rd_chk("ctrl_busy", 8'h80, 32'h2);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    for (int p = 0; p < NP; p++) act_m[p] = 0;
    mask_m = '0;
    pads_chk("rst_mid", 1'b0);
    wb_rst_i = 1'b0;
    wr(8'h88, 32'd0, 4'hF);
    rd_chk("rst_mid_active", 8'h88, 32'd0);
    rd_chk("rst_mid_sel0", 8'h00, 32'h0);
    rd_chk("rst_mid_err", 8'h84, 32'h0);

    // Partial byte write: only byte lane 2 lands
    wr(8'h00, 32'hAA0B_CCDD, 4'b0100);
    rd_chk("part_sel0", 8'h00, 32'h000B_0000);
    rd_chk("part_err", 8'h84, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
